video_mnist_color_ctrl: RTL and testbench

//  Register-mapped controller for the MNIST colour-overlay stage; drives its param_mode/param_th.

---
 rtl/video_mnist_color_ctrl_pkg.sv | 19 +
 rtl/video_mnist_color_ctrl_timer.sv | 28 ++
 rtl/video_mnist_color_ctrl.sv | 173 +++++++++++++++++
 tb/tb_video_mnist_color_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_mnist_color_ctrl_pkg.sv
// Shared definitions for the MNIST colour-overlay controller: register map, core ID, FSM encoding.
package video_mnist_color_ctrl_pkg;

    localparam int unsigned REG_CORE_ID     = 0;
    localparam int unsigned REG_CONTROL     = 1;
    localparam int unsigned REG_STATUS      = 2;
    localparam int unsigned REG_FRAME_COUNT = 3;
    localparam int unsigned REG_SHADOW_MODE = 4;
    localparam int unsigned REG_SHADOW_TH   = 5;
    localparam int unsigned REG_TIMEOUT     = 6;
    localparam int unsigned REG_APPLIED     = 7;

    localparam logic [31:0] CORE_ID = 32'h527A_F00D;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_APPLY = 2'd2;

endpackage

// File: rtl/video_mnist_color_ctrl_timer.sv
// Frame-timeout counter used while an update waits for a frame start.
module video_mnist_color_ctrl_timer #(
    parameter int unsigned WIDTH = 24
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] limit,
    output logic             expire
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + WIDTH'(1);
        end
    end

    // Fires on the cycle whose increment reaches the limit, so exactly 'limit' enabled cycles elapse.
    assign expire = enable && (limit != '0) && ((count + WIDTH'(1)) == limit);

endmodule

// File: rtl/video_mnist_color_ctrl.sv
// MNIST colour-overlay controller: WISHBONE shadow registers applied at frame start or on timeout.
// Optional build macro VIDEO_MNIST_COLOR_CTRL_BLINK_EN adds a frame-periodic blink of param_mode[1].
module video_mnist_color_ctrl
    import video_mnist_color_ctrl_pkg::*;
#(
    parameter int unsigned               TUSER_WIDTH   = 1,
    parameter int unsigned               TCOUNT_WIDTH  = 4,
    parameter int unsigned               WB_ADR_WIDTH  = 3,
    parameter int unsigned               WB_DAT_WIDTH  = 32,
    parameter logic [1:0]                INIT_MODE     = 2'b00,
    parameter logic [TCOUNT_WIDTH-1:0]   INIT_TH       = '0,
    parameter int unsigned               TIMEOUT_WIDTH = 24,
    parameter logic [TIMEOUT_WIDTH-1:0]  INIT_TIMEOUT  = '1
) (
    input  logic                      aresetn,
    input  logic                      aclk,
    input  logic [WB_ADR_WIDTH-1:0]   s_wb_adr_i,
    input  logic [WB_DAT_WIDTH-1:0]   s_wb_dat_i,
    output logic [WB_DAT_WIDTH-1:0]   s_wb_dat_o,
    input  logic                      s_wb_we_i,
    input  logic [WB_DAT_WIDTH/8-1:0] s_wb_sel_i,
    input  logic                      s_wb_stb_i,
    output logic                      s_wb_ack_o,
    input  logic [TUSER_WIDTH-1:0]    mon_tuser,
    input  logic                      mon_tvalid,
    input  logic                      mon_tready,
    output logic [1:0]                param_mode,
    output logic [TCOUNT_WIDTH-1:0]   param_th,
    output logic                      update_busy,
    output logic                      irq_frame
);

    logic [1:0]               state;
    logic [1:0]               param_mode_r;
    logic [TCOUNT_WIDTH-1:0]  param_th_r;
    logic [1:0]               shadow_mode;
    logic [TCOUNT_WIDTH-1:0]  shadow_th;
    logic [TIMEOUT_WIDTH-1:0] timeout_r;
    logic                     auto_en;
    logic [31:0]              frame_count;
    logic                     frame_start;
    logic                     timer_expire;
    logic                     wr_en;
    logic                     hit_control;
    logic                     hit_mode;
    logic                     hit_th;
    logic                     hit_timeout;
    logic                     start_req;
    logic                     mode_hi_gate;
    logic                     unused_inputs;

    assign unused_inputs = ^{s_wb_sel_i, s_wb_dat_i, mon_tuser};

    assign frame_start = mon_tuser[0] & mon_tvalid & mon_tready;
    assign wr_en       = s_wb_stb_i & s_wb_we_i & s_wb_sel_i[0];
    assign hit_control = (s_wb_adr_i == WB_ADR_WIDTH'(REG_CONTROL));
    assign hit_mode    = (s_wb_adr_i == WB_ADR_WIDTH'(REG_SHADOW_MODE));
    assign hit_th      = (s_wb_adr_i == WB_ADR_WIDTH'(REG_SHADOW_TH));
    assign hit_timeout = (s_wb_adr_i == WB_ADR_WIDTH'(REG_TIMEOUT));
    assign start_req   = wr_en & ((hit_control & s_wb_dat_i[0]) | (auto_en & (hit_mode | hit_th)));

    assign s_wb_ack_o  = s_wb_stb_i;
    assign update_busy = (state != ST_IDLE);
    assign param_th    = param_th_r;
    assign param_mode  = {param_mode_r[1] & mode_hi_gate, param_mode_r[0]};

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            auto_en     <= 1'b0;
            shadow_mode <= INIT_MODE;
            shadow_th   <= INIT_TH;
            timeout_r   <= INIT_TIMEOUT;
        end else if (wr_en) begin
            if (hit_control) auto_en     <= s_wb_dat_i[1];
            if (hit_mode)    shadow_mode <= s_wb_dat_i[1:0];
            if (hit_th)      shadow_th   <= s_wb_dat_i[TCOUNT_WIDTH-1:0];
            if (hit_timeout) timeout_r   <= s_wb_dat_i[TIMEOUT_WIDTH-1:0];
        end
    end

    // IDLE ignores frame starts, so a request landing with fs waits for the next frame.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state        <= ST_IDLE;
            param_mode_r <= INIT_MODE;
            param_th_r   <= INIT_TH;
        end else begin
            case (state)
                ST_IDLE:  if (start_req) state <= ST_WAIT;
                ST_WAIT:  if (frame_start || timer_expire) state <= ST_APPLY;
                ST_APPLY: begin
                    param_mode_r <= shadow_mode;
                    param_th_r   <= shadow_th;
                    state        <= ST_IDLE;
                end
                default:  state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            frame_count <= '0;
            irq_frame   <= 1'b0;
        end else begin
            irq_frame <= frame_start;
            if (frame_start) frame_count <= frame_count + 32'd1;
        end
    end

    video_mnist_color_ctrl_timer #(
        .WIDTH(TIMEOUT_WIDTH)
    ) u_timer (
        .aclk    (aclk),
        .aresetn (aresetn),
        .clear   (state != ST_WAIT),
        .enable  (state == ST_WAIT),
        .limit   (timeout_r),
        .expire  (timer_expire)
    );

`ifdef VIDEO_MNIST_COLOR_CTRL_BLINK_EN
    logic [15:0] blink_period;
    logic [15:0] blink_cnt;
    logic        blink_pass;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            blink_period <= '0;
        end else if (wr_en && (s_wb_adr_i == WB_ADR_WIDTH'(REG_CORE_ID))) begin
            blink_period <= s_wb_dat_i[15:0];
        end
    end

    // Phase restarts on every apply with the forced-low half first.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            blink_cnt  <= '0;
            blink_pass <= 1'b0;
        end else if (state == ST_APPLY) begin
            blink_cnt  <= '0;
            blink_pass <= 1'b0;
        end else if (frame_start && (blink_period != '0)) begin
            if (blink_cnt == blink_period - 16'd1) begin
                blink_cnt  <= '0;
                blink_pass <= ~blink_pass;
            end else begin
                blink_cnt <= blink_cnt + 16'd1;
            end
        end
    end

    assign mode_hi_gate = (blink_period == '0) | blink_pass;
`else
    assign mode_hi_gate = 1'b1;
`endif

    always_comb begin
        s_wb_dat_o = '0;
        case (s_wb_adr_i)
            WB_ADR_WIDTH'(REG_CORE_ID):     s_wb_dat_o = WB_DAT_WIDTH'(CORE_ID);
            WB_ADR_WIDTH'(REG_CONTROL):     s_wb_dat_o = WB_DAT_WIDTH'({auto_en, 1'b0});
            WB_ADR_WIDTH'(REG_STATUS):      s_wb_dat_o = WB_DAT_WIDTH'(update_busy);
            WB_ADR_WIDTH'(REG_FRAME_COUNT): s_wb_dat_o = WB_DAT_WIDTH'(frame_count);
            WB_ADR_WIDTH'(REG_SHADOW_MODE): s_wb_dat_o = WB_DAT_WIDTH'(shadow_mode);
            WB_ADR_WIDTH'(REG_SHADOW_TH):   s_wb_dat_o = WB_DAT_WIDTH'(shadow_th);
            WB_ADR_WIDTH'(REG_TIMEOUT):     s_wb_dat_o = WB_DAT_WIDTH'(timeout_r);
            WB_ADR_WIDTH'(REG_APPLIED):     s_wb_dat_o = WB_DAT_WIDTH'({param_th_r, param_mode_r});
            default:                        s_wb_dat_o = '0;
        endcase
    end

endmodule

// File: tb/tb_video_mnist_color_ctrl.sv
// Randomized and directed bench for video_mnist_color_ctrl against a transaction-level reference model.
module tb_video_mnist_color_ctrl;

    localparam logic [31:0] EXP_CORE_ID = 32'h527A_F00D;
    localparam logic [2:0]  FS   = 3'b111;
    localparam logic [2:0]  NOFS = 3'b000;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [2:0]  s_wb_adr_i;
    logic [31:0] s_wb_dat_i;
    logic [31:0] s_wb_dat_o;
    logic        s_wb_we_i;
    logic [3:0]  s_wb_sel_i;
    logic        s_wb_stb_i;
    logic        s_wb_ack_o;
    logic [0:0]  mon_tuser;
    logic        mon_tvalid;
    logic        mon_tready;
    logic [1:0]  param_mode;
    logic [3:0]  param_th;
    logic        update_busy;
    logic        irq_frame;

    always #5 aclk = ~aclk;

    video_mnist_color_ctrl #(
        .TUSER_WIDTH   (1),
        .TCOUNT_WIDTH  (4),
        .WB_ADR_WIDTH  (3),
        .WB_DAT_WIDTH  (32),
        .INIT_MODE     (2'b00),
        .INIT_TH       (4'd0),
        .TIMEOUT_WIDTH (24),
        .INIT_TIMEOUT  (24'hff_ffff)
    ) dut (
        .aresetn     (aresetn),
        .aclk        (aclk),
        .s_wb_adr_i  (s_wb_adr_i),
        .s_wb_dat_i  (s_wb_dat_i),
        .s_wb_dat_o  (s_wb_dat_o),
        .s_wb_we_i   (s_wb_we_i),
        .s_wb_sel_i  (s_wb_sel_i),
        .s_wb_stb_i  (s_wb_stb_i),
        .s_wb_ack_o  (s_wb_ack_o),
        .mon_tuser   (mon_tuser),
        .mon_tvalid  (mon_tvalid),
        .mon_tready  (mon_tready),
        .param_mode  (param_mode),
        .param_th    (param_th),
        .update_busy (update_busy),
        .irq_frame   (irq_frame)
    );

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expd);
        n_vec++;
        if (obs !== expd) begin
            n_err++;
            $display("FAIL %s: got %h, want %h (t=%0t)", tag, obs, expd, $time);
        end
    endtask

    // Reference model: an update is either absent, pending a frame/timeout, or due this edge.
    logic [1:0]  m_app_mode, m_sh_mode;
    logic [3:0]  m_app_th, m_sh_th;
    logic        m_auto, m_irq;
    logic [23:0] m_timeout;
    logic [31:0] m_fc;
    bit          m_pending, m_apply_now;
    int unsigned m_waited, m_frames, m_period;

    task automatic model_reset();
        m_app_mode = 2'b00; m_sh_mode = 2'b00;
        m_app_th = 4'd0; m_sh_th = 4'd0;
        m_auto = 1'b0; m_irq = 1'b0;
        m_timeout = 24'hff_ffff; m_fc = '0;
        m_pending = 0; m_apply_now = 0;
        m_waited = 0; m_frames = 0; m_period = 0;
    endtask

    function automatic logic [1:0] exp_mode();
        logic hi;
        hi = m_app_mode[1];
`ifdef VIDEO_MNIST_COLOR_CTRL_BLINK_EN
        if (m_period != 0 && ((m_frames / m_period) % 2 == 0)) hi = 1'b0;
`endif
        return {hi, m_app_mode[0]};
    endfunction

    function automatic logic [31:0] model_read(input logic [2:0] adr);
        case (adr)
            3'd0: return EXP_CORE_ID;
            3'd1: return {30'd0, m_auto, 1'b0};
            3'd2: return {31'd0, m_pending || m_apply_now};
            3'd3: return m_fc;
            3'd4: return {30'd0, m_sh_mode};
            3'd5: return {28'd0, m_sh_th};
            3'd6: return {8'd0, m_timeout};
            default: return {26'd0, m_app_th, m_app_mode};
        endcase
    endfunction

    task automatic model_step(input logic stb, input logic we, input logic [2:0] adr,
                              input logic [31:0] dat, input logic [3:0] sel, input logic fs);
        bit wr, start;
        wr    = stb && we && sel[0];
        start = wr && ((adr == 3'd1 && dat[0]) || (m_auto && (adr == 3'd4 || adr == 3'd5)));
        if (m_apply_now) begin
            m_app_mode = m_sh_mode;
            m_app_th = m_sh_th;
            m_apply_now = 0;
            m_pending = 0;
            m_frames = 0;
        end else begin
            if (fs) m_frames++;
            if (m_pending) begin
                m_waited++;
                if (fs || (m_timeout != 0 && m_waited == m_timeout)) m_apply_now = 1;
            end else if (start) begin
                m_pending = 1;
                m_waited = 0;
            end
        end
        if (fs) m_fc = m_fc + 32'd1;
        m_irq = fs;
        if (wr) begin
            case (adr)
                3'd1: m_auto = dat[1];
                3'd4: m_sh_mode = dat[1:0];
                3'd5: m_sh_th = dat[3:0];
                3'd6: m_timeout = dat[23:0];
`ifdef VIDEO_MNIST_COLOR_CTRL_BLINK_EN
                3'd0: m_period = int'(dat[15:0]);
`endif
                default: ;
            endcase
        end
    endtask

    task automatic cycle(input logic stb, input logic we, input logic [2:0] adr,
                         input logic [31:0] dat, input logic [3:0] sel, input logic [2:0] mon);
        @(negedge aclk);
        check_val("param_mode", {30'd0, param_mode}, {30'd0, exp_mode()});
        check_val("param_th", {28'd0, param_th}, {28'd0, m_app_th});
        check_val("update_busy", {31'd0, update_busy}, {31'd0, m_pending || m_apply_now});
        check_val("irq_frame", {31'd0, irq_frame}, {31'd0, m_irq});
        s_wb_stb_i = stb; s_wb_we_i = we; s_wb_adr_i = adr;
        s_wb_dat_i = dat; s_wb_sel_i = sel;
        mon_tuser[0] = mon[2]; mon_tvalid = mon[1]; mon_tready = mon[0];
        #1;
        check_val("ack", {31'd0, s_wb_ack_o}, {31'd0, stb});
        if (stb && !we) check_val("rdata", s_wb_dat_o, model_read(adr));
        model_step(stb, we, adr, dat, sel, &mon);
    endtask

    task automatic idle();                                    cycle(1'b0, 1'b0, 3'd0, 32'd0, 4'h0, NOFS); endtask
    task automatic frame();                                   cycle(1'b0, 1'b0, 3'd0, 32'd0, 4'h0, FS);   endtask
    task automatic wr(input logic [2:0] a, input logic [31:0] d); cycle(1'b1, 1'b1, a, d, 4'hF, NOFS);   endtask
    task automatic rd(input logic [2:0] a);                   cycle(1'b1, 1'b0, a, 32'd0, 4'hF, NOFS);   endtask

    task automatic drive_idle();
        s_wb_stb_i = 1'b0; s_wb_we_i = 1'b0; s_wb_adr_i = '0;
        s_wb_dat_i = '0; s_wb_sel_i = '0;
        mon_tuser = '0; mon_tvalid = 1'b0; mon_tready = 1'b0;
    endtask

    task automatic check_init(input string tag);
        check_val({tag, "_mode"}, {30'd0, param_mode}, 32'd0);
        check_val({tag, "_th"}, {28'd0, param_th}, 32'd0);
        check_val({tag, "_busy"}, {31'd0, update_busy}, 32'd0);
        check_val({tag, "_irq"}, {31'd0, irq_frame}, 32'd0);
    endtask

    task automatic do_reset();
        @(negedge aclk);
        drive_idle();
        #2 aresetn = 1'b0;
        #1 check_init("async_rst");
        model_reset();
        @(negedge aclk);
        aresetn = 1'b1;
    endtask

    initial begin
        logic [6:0] blink_seq;
        int unsigned r;
        logic [2:0] mon, a;
        logic [31:0] d;

        drive_idle();
        model_reset();
        aresetn = 1'b0;
        #12 check_init("por");
        @(negedge aclk);
        aresetn = 1'b1;

        // Reset register contents
        rd(3'd7); check_val("applied_rst", s_wb_dat_o, 32'd0);
        rd(3'd0); check_val("core_id", s_wb_dat_o, EXP_CORE_ID);
        rd(3'd6); check_val("timeout_rst", s_wb_dat_o, 32'h00ff_ffff);
        wr(3'd0, 32'h0000_1234);
        rd(3'd0); check_val("core_id_ro", s_wb_dat_o, EXP_CORE_ID);

        // Frame-start apply, two cycles after fs
        wr(3'd4, 32'd2); wr(3'd5, 32'd5); wr(3'd1, 32'd1);
        repeat (100) idle();
        check_val("t2_busy_wait", {31'd0, update_busy}, 32'd1);
        check_val("t2_th_hold", {28'd0, param_th}, 32'd0);
        frame();
        idle();
        check_val("t2_busy_apply", {31'd0, update_busy}, 32'd1);
        check_val("t2_th_apply", {28'd0, param_th}, 32'd0);
        idle();
        check_val("t2_mode", {30'd0, param_mode}, 32'd2);
        check_val("t2_th", {28'd0, param_th}, 32'd5);
        check_val("t2_busy_done", {31'd0, update_busy}, 32'd0);

        // Timeout apply after exactly 50 WAIT cycles
        wr(3'd6, 32'd50); wr(3'd4, 32'd1); wr(3'd5, 32'd9); wr(3'd1, 32'd1);
        for (int i = 0; i < 51; i++) begin
            idle();
            check_val("t3_busy", {31'd0, update_busy}, 32'd1);
            check_val("t3_th_hold", {28'd0, param_th}, 32'd5);
        end
        idle();
        check_val("t3_busy_drop", {31'd0, update_busy}, 32'd0);
        check_val("t3_th", {28'd0, param_th}, 32'd9);
        check_val("t3_mode", {30'd0, param_mode}, 32'd1);

        // Auto mode: newest shadow value wins, single apply
        wr(3'd1, 32'd2);
        wr(3'd5, 32'd3);
        repeat (5) idle();
        check_val("t4_busy", {31'd0, update_busy}, 32'd1);
        wr(3'd5, 32'd7);
        repeat (3) idle();
        frame(); idle(); idle();
        check_val("t4_th", {28'd0, param_th}, 32'd7);
        repeat (10) idle();
        check_val("t4_single", {31'd0, update_busy}, 32'd0);
        wr(3'd1, 32'd0);

        // Timeout of zero never forces an apply
        wr(3'd6, 32'd0); wr(3'd5, 32'd1); wr(3'd1, 32'd1);
        repeat (70) idle();
        check_val("t0_busy", {31'd0, update_busy}, 32'd1);
        check_val("t0_th_hold", {28'd0, param_th}, 32'd7);
        frame(); idle(); idle();
        check_val("t0_th", {28'd0, param_th}, 32'd1);

        // Request coinciding with fs waits for the next frame
        wr(3'd5, 32'd4);
        cycle(1'b1, 1'b1, 3'd1, 32'd1, 4'hF, FS);
        repeat (3) idle();
        check_val("t5_busy", {31'd0, update_busy}, 32'd1);
        check_val("t5_th_hold", {28'd0, param_th}, 32'd1);
        frame(); idle(); idle();
        check_val("t5_th", {28'd0, param_th}, 32'd4);

        // Reset during WAIT discards the pending update
        wr(3'd5, 32'd6); wr(3'd1, 32'd1);
        repeat (3) idle();
        do_reset();
        idle();
        check_init("t5_after_rst");
        rd(3'd5); check_val("t5_shadow_rst", s_wb_dat_o, 32'd0);
        rd(3'd3); check_val("t5_fc_rst", s_wb_dat_o, 32'd0);

        // Randomized traffic against the model
        wr(3'd6, 32'd30);
        for (int n = 0; n < 3000; n++) begin
            r = $urandom_range(0, 99);
            mon = ($urandom_range(0, 99) < 6) ? FS : 3'($urandom_range(0, 6));
            if (r < 25) begin
                cycle(1'b1, 1'b0, 3'($urandom_range(0, 7)), $urandom, 4'hF, mon);
            end else if (r < 45) begin
                a = 3'($urandom_range(1, 7));
                d = (a == 3'd6) ? 32'($urandom_range(0, 40)) : $urandom;
                cycle(1'b1, 1'b1, a, d, ($urandom_range(0, 4) == 0) ? 4'hE : 4'hF, mon);
            end else begin
                cycle(1'b0, 1'b0, 3'd0, 32'd0, 4'h0, mon);
            end
        end

`ifdef VIDEO_MNIST_COLOR_CTRL_BLINK_EN
        // Blink with period 2: forced-low for two frames, then passes for two
        do_reset();
        wr(3'd0, 32'd2); wr(3'd4, 32'd2); wr(3'd1, 32'd1);
        idle(); frame(); idle(); idle();
        blink_seq = 7'b1001100;
        for (int i = 0; i < 7; i++) begin
            check_val("blink_mode1", {31'd0, param_mode[1]}, {31'd0, blink_seq[i]});
            cycle(1'b1, 1'b0, 3'd3, 32'd0, 4'hF, FS);
            check_val("blink_fc", s_wb_dat_o, 32'(1 + i));
            idle();
        end
        rd(3'd0); check_val("blink_core_id", s_wb_dat_o, EXP_CORE_ID);
`else
        blink_seq = '0;
`endif

        repeat (3) idle();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
